// File: rtl/ext_mem_bridge.sv
// CPU-to-external 8-bit asynchronous memory sequencer with programmable wait states.
// Define MEM_TIMEOUT_EN to abort transfers whose mem_ready stays low for TIMEOUT cycles.
module ext_mem_bridge #(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_rw,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_busy,
    output logic [7:0]  mem_addr_l,
    output logic [7:0]  mem_addr_h,
    inout  wire  [7:0]  mem_data,
    output logic        mem_rw,
    output logic        mem_ce,
    input  logic        mem_ready,
    output logic        timeout_err
);

    if (WAIT_STATES > 15 || TIMEOUT == 0) begin : g_param_check
        $error("ext_mem_bridge: WAIT_STATES must be 0..15 and TIMEOUT nonzero");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic [3:0]  wait_q, wait_d;
    logic [7:0]  rdata_q, rdata_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned ToW = $clog2(TIMEOUT + 1);

    logic [ToW-1:0] to_q, to_d;
    logic           err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        wait_d  = wait_q;
        rdata_d = rdata_q;
`ifdef MEM_TIMEOUT_EN
        to_d    = to_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    rw_d    = cpu_rw;
                    state_d = StSetup;
`ifdef MEM_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            StSetup: begin
                wait_d  = 4'(WAIT_STATES);
                state_d = StAccess;
`ifdef MEM_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            StAccess: begin
                // mem_ready only matters once the programmed wait states have elapsed
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else if (mem_ready) begin
                    if (!rw_q) rdata_d = mem_data;
                    state_d = StHold;
                end
`ifdef MEM_TIMEOUT_EN
                else if (to_q == ToW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    if (!rw_q) rdata_d = 8'hFF;
                    state_d = StHold;
                end else begin
                    to_d = to_q + 1'b1;
                end
`endif
            end
            StHold: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            rw_q    <= 1'b0;
            wait_q  <= 4'd0;
            rdata_q <= 8'h00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_q  <= '0;
            err_q <= 1'b0;
        end else begin
            to_q  <= to_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Outputs decode straight from state so an async reset releases the bus at once
    assign cpu_busy   = (state_q != StIdle);
    assign cpu_ack    = (state_q == StHold);
    assign mem_ce     = (state_q != StIdle);
    assign mem_rw     = (state_q == StAccess) && rw_q;
    assign mem_addr_l = addr_q[7:0];
    assign mem_addr_h = addr_q[15:8];
    assign cpu_rdata  = rdata_q;
    assign mem_data   = (rw_q && (state_q == StAccess || state_q == StHold)) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Directed self-checking bench for ext_mem_bridge (WAIT_STATES = 2, TIMEOUT = 8).
module tb_ext_mem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_rw;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ack;
    logic        cpu_busy;
    logic [7:0]  mem_addr_l;
    logic [7:0]  mem_addr_h;
    wire  [7:0]  mem_data;
    logic        mem_rw;
    logic        mem_ce;
    logic        mem_ready;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    // 0: bench leaves bus alone, 1: park 8'h69, 2: act as memory on reads
    int         tb_mode;
    logic       tb_en;
    logic [7:0] tb_val;
    logic       tb_we;
    logic [7:0] tb_waddr;
    logic [7:0] tb_wdat;
    logic [7:0] mem_model [256];

    // Per-transfer observations
    int          r_ack_cyc, r_ack_cnt, r_busy_cnt, r_rw_cnt, r_rw_first, r_drv_cnt;
    logic [15:0] r_addr_setup, r_addr_hold;
    logic        r_ce_setup, r_rw_setup, r_err_ack;

    always #5 clk = ~clk;

    ext_mem_bridge #(
        .WAIT_STATES(2),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ack    (cpu_ack),
        .cpu_busy   (cpu_busy),
        .mem_addr_l (mem_addr_l),
        .mem_addr_h (mem_addr_h),
        .mem_data   (mem_data),
        .mem_rw     (mem_rw),
        .mem_ce     (mem_ce),
        .mem_ready  (mem_ready),
        .timeout_err(timeout_err)
    );

    always_comb begin
        tb_en  = (tb_mode == 1) || (tb_mode == 2 && mem_ce && !mem_rw);
        tb_val = (tb_mode == 1) ? 8'h69 : mem_model[mem_addr_l];
    end

    assign mem_data = tb_en ? tb_val : 8'hzz;

    always @(posedge clk) begin
        if (mem_ce && mem_rw) mem_model[mem_addr_l] <= mem_data;
        else if (tb_we)       mem_model[tb_waddr]   <= tb_wdat;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic mem_load(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdat  = d;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    // Cycle 0 holds the request; observes cycles 1..20. mem_ready low for cycles lo_from..lo_to,
    // a stray cpu_req is raised in cycle inj.
    task automatic xfer(input logic rw, input logic [15:0] addr, input logic [7:0] wd,
                        input int lo_from, input int lo_to, input int inj);
        @(negedge clk);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wd;
        mem_ready = 1'b1;
        tb_mode   = rw ? 0 : 2;
        r_ack_cyc = -1; r_ack_cnt = 0; r_busy_cnt = 0; r_rw_cnt = 0; r_rw_first = -1;
        r_drv_cnt = 0; r_err_ack = 1'bx; r_addr_hold = 16'h0; r_addr_setup = 16'h0;
        r_ce_setup = 1'b0; r_rw_setup = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (cpu_ack) begin
                r_ack_cnt++;
                if (r_ack_cyc < 0) begin
                    r_ack_cyc   = c;
                    r_addr_hold = {mem_addr_h, mem_addr_l};
                    r_err_ack   = timeout_err;
                end
            end
            if (cpu_busy) r_busy_cnt++;
            if (mem_rw) begin
                r_rw_cnt++;
                if (r_rw_first < 0) r_rw_first = c;
            end
            if (c == 1) begin
                r_addr_setup = {mem_addr_h, mem_addr_l};
                r_ce_setup   = mem_ce;
                r_rw_setup   = mem_rw;
            end
            if (rw && c >= 2 && cpu_busy && mem_data === wd) r_drv_cnt++;
            cpu_req   = (c == inj);
            cpu_addr  = 16'hDEAD;
            cpu_wdata = 8'h99;
            mem_ready = !(c >= lo_from && c <= lo_to);
        end
        cpu_req   = 1'b0;
        mem_ready = 1'b1;
        tb_mode   = 1;
    endtask

    initial begin
        rst = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
        mem_ready = 1'b1; tb_mode = 1; tb_we = 1'b0; tb_waddr = 8'h0; tb_wdat = 8'h0;
        repeat (3) @(negedge clk);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_ack", cpu_ack, 1'b0);
        check("rst_busy", cpu_busy, 1'b0);
        check("rst_addr", {mem_addr_h, mem_addr_l}, 16'h0000);
        check("rst_rw_ce", {mem_rw, mem_ce}, 2'b00);
        check("rst_err", timeout_err, 1'b0);
        check("rst_bus_free", mem_data, 8'h69);
        rst = 1'b0;

        mem_load(8'h34, 8'hA5);
        xfer(1'b0, 16'h1234, 8'h00, 99, 0, 5);
        check("rd1_setup_addr", r_addr_setup, 16'h1234);
        check("rd1_setup_ce_rw", {r_ce_setup, r_rw_setup}, 2'b10);
        check("rd1_ack_cycle", r_ack_cyc, 5);
        check("rd1_ack_count", r_ack_cnt, 1);
        check("rd1_busy_cycles", r_busy_cnt, 5);
        check("rd1_hold_addr", r_addr_hold, 16'h1234);
        check("rd1_rdata", cpu_rdata, 8'hA5);
        check("rd1_err", r_err_ack, 1'b0);

        xfer(1'b1, 16'h00FF, 8'h3C, 99, 0, 0);
        check("wr_ack_cycle", r_ack_cyc, 5);
        check("wr_rw_cycles", r_rw_cnt, 3);
        check("wr_rw_first", r_rw_first, 2);
        check("wr_data_driven", r_drv_cnt, 4);
        check("wr_mem", mem_model[8'hFF], 8'h3C);
        check("wr_rdata_kept", cpu_rdata, 8'hA5);
        #1;
        check("wr_bus_released", mem_data, 8'h69);

        mem_load(8'h01, 8'h5E);
        xfer(1'b0, 16'h8001, 8'h00, 3, 7, 4);
        check("rd2_ack_cycle", r_ack_cyc, 9);
        check("rd2_ack_count", r_ack_cnt, 1);
        check("rd2_busy_cycles", r_busy_cnt, 9);
        check("rd2_rdata", cpu_rdata, 8'h5E);

        xfer(1'b0, 16'hFFFF, 8'h00, 99, 0, 0);
        check("rdff_setup_addr", r_addr_setup, 16'hFFFF);
        check("rdff_hold_addr", r_addr_hold, 16'hFFFF);
        check("rdff_rdata", cpu_rdata, 8'h3C);

`ifdef MEM_TIMEOUT_EN
        xfer(1'b0, 16'h1234, 8'h00, 2, 20, 0);
        check("to_ack_cycle", r_ack_cyc, 12);
        check("to_err_at_ack", r_err_ack, 1'b1);
        check("to_rdata", cpu_rdata, 8'hFF);
        check("to_err_held", timeout_err, 1'b1);
        xfer(1'b0, 16'h1234, 8'h00, 99, 0, 0);
        check("to_clr_err", r_err_ack, 1'b0);
        check("to_clr_rdata", cpu_rdata, 8'hA5);
`endif

        // Reset in the middle of a write ACCESS
        @(negedge clk);
        tb_mode = 0; cpu_req = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 8'h77;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rstmid_in_access", mem_rw, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_rw_ce", {mem_rw, mem_ce}, 2'b00);
        check("rstmid_busy_ack", {cpu_busy, cpu_ack}, 2'b00);
        tb_mode = 1;
        #1;
        check("rstmid_bus_free", mem_data, 8'h69);
        @(negedge clk);
        rst = 1'b0;
        r_ack_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (cpu_ack) r_ack_cnt++;
        end
        check("rstmid_no_ack", r_ack_cnt, 0);
        check("rstmid_rdata", cpu_rdata, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ext_mem_bridge.md
Name: ext_mem_bridge

Overview:
- Sequencer between the CPU core's memory-transfer request and the off-chip 8-bit asynchronous memory.
- Drives the split address bus (mem_addr_l / mem_addr_h), the bidirectional mem_data bus, mem_rw and chip enable, with programmable wait states.
- Upstream: CPU control and memory buses. Downstream: external SRAM/ROM pins.
- Returns read data and a one-cycle acknowledge to the CPU.

Parameters:
- WAIT_STATES, 2, extra ACCESS cycles before data is sampled or the write completes (0..15).
- TIMEOUT, 64, maximum cycles mem_ready may stay low after wait states expire (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cpu_req  input  1  single-cycle transfer request; sampled only in IDLE.
- cpu_rw  input  1  1 = write, 0 = read.
- cpu_addr  input  16  transfer address.
- cpu_wdata  input  8  write data.
- cpu_rdata  output  8  registered read data.
- cpu_ack  output  1  one-cycle completion pulse.
- cpu_busy  output  1  high whenever state != IDLE.
- mem_addr_l  output  8  address bits 7:0.
- mem_addr_h  output  8  address bits 15:8.
- mem_data  inout  8  external data; driven only during write ACCESS/HOLD, otherwise high-Z.
- mem_rw  output  1  1 = write strobe active, 0 = read/idle.
- mem_ce  output  1  chip enable, active high.
- mem_ready  input  1  external ready; low stretches ACCESS.
- timeout_err  output  1  registered, set with the ack of an aborted transfer.

Behaviour:
- Reset values (asynchronous): state IDLE, cpu_rdata = 8'h00, cpu_ack = 0, cpu_busy = 0, mem_addr = 16'h0000, mem_rw = 0, mem_ce = 0, mem_data high-Z, timeout_err = 0, wait counter = 0.
- Reset mid-transfer aborts immediately: no ack, bus released in the same cycle.
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- IDLE:
  - mem_ce = 0, mem_rw = 0.
  - When cpu_req = 1, latch cpu_addr, cpu_wdata and cpu_rw, then go to SETUP.
- SETUP (1 cycle):
  - Latched address driven, mem_ce = 1, mem_rw = 0. mem_rw is never high in SETUP, so no address-transition write.
  - Load the wait counter with WAIT_STATES, then go to ACCESS.
- ACCESS:
  - mem_ce = 1, mem_rw = latched rw; mem_data driven with latched wdata if write.
  - Counter decrements each cycle while > 0.
  - When counter == 0 and mem_ready = 1: on a read, capture mem_data into cpu_rdata at this edge; go to HOLD.
  - mem_ready is ignored while counter > 0.
- HOLD (1 cycle):
  - mem_rw = 0, mem_ce = 1; write data is still driven (data hold time).
  - cpu_ack = 1; timeout_err is valid alongside it.
  - Next state IDLE.
- Latency: request-sampling edge to ack cycle is WAIT_STATES + 3 cycles with mem_ready held high. With WAIT_STATES = 0 the latency is 3 cycles.
- cpu_req while busy is ignored, with no queueing. cpu_req in the HOLD cycle is also ignored; the earliest next accept is the following IDLE cycle.
- cpu_rdata holds its value until the next read completes. Writes never change it.
- The latched address is stable from SETUP through HOLD. Changes on cpu_addr/cpu_wdata during a transfer have no effect.
- Address 16'hFFFF and any other value pass unmodified; the block does no incrementing or wrap.
- timeout_err clears when the next transfer is accepted.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - In ACCESS, once counter == 0, count consecutive mem_ready = 0 cycles.
  - On reaching TIMEOUT, abort to HOLD: cpu_ack = 1, timeout_err = 1; on a read, cpu_rdata = 8'hFF.
  - The timeout count restarts for every transfer.
- MEM_TIMEOUT_EN undefined:
  - ACCESS waits indefinitely for mem_ready.
  - timeout_err is tied 0 and no timeout counter is built.

Test Plan:
- Reset then idle: rst pulse → all outputs at their reset values, mem_data high-Z, cpu_busy = 0.
- Read, WAIT_STATES = 2, mem_ready = 1, addr 16'h1234, memory returns 8'hA5 → mem_addr_h = 8'h12, mem_addr_l = 8'h34 from SETUP; cpu_ack 5 cycles after the request edge; cpu_rdata = 8'hA5.
- Write addr 16'h00FF, data 8'h3C → mem_rw high only during the 3 ACCESS cycles; mem_data = 8'h3C from ACCESS through HOLD; memory holds 8'h3C; cpu_rdata unchanged.
- Read with mem_ready low for 4 cycles after wait states → ACCESS extended by 4; ack at cycle 9; second cpu_req issued mid-transfer is ignored (only one ack).
- rst asserted during a write ACCESS → mem_rw = 0, mem_ce = 0, mem_data high-Z immediately; no cpu_ack.
- MEM_TIMEOUT_EN with TIMEOUT = 8, mem_ready stuck 0 on a read → ack with timeout_err = 1 and cpu_rdata = 8'hFF; the next successful transfer clears timeout_err.
